ucsbece154a_muldiv: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers for the multicycle MIPS core.
- Sits directly downstream of the register file: operands are the latched rd1/rd2 values (A/B registers).
- HI/LO results return to the register file write port via mfhi/mflo through the existing result mux.
- Executes MULT, MULTU, DIV and DIVU in 34 cycles; the controller stalls on busy_o.

---
 rtl/ucsbece154a_muldiv_pkg.sv | 20 ++
 rtl/ucsbece154a_muldiv_dp.sv | 61 ++++++
 rtl/ucsbece154a_muldiv.sv | 134 +++++++++++++
 tb/tb_ucsbece154a_muldiv.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ucsbece154a_muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package ucsbece154a_muldiv_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned MD_STEPS = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/ucsbece154a_muldiv_dp.sv
// Radix-2 datapath: shift-add multiply / restoring divide on unsigned magnitudes.
module ucsbece154a_muldiv_dp
    import ucsbece154a_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 div_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q;
    logic               div_q;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     upper;
    logic [2*WIDTH:0]   sh;
    logic [WIDTH:0]     trial;

    // Multiply keeps the multiplier in the low half and shifts right;
    // divide keeps {remainder, dividend} and shifts left.
    always_comb begin
        acc_d = acc_q;
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        sh    = {acc_q, 1'b0};
        trial = sh[2*WIDTH:WIDTH] - {1'b0, b_q};
        upper = acc_q[0] ? sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (div_q) begin
            if (sh[2*WIDTH:WIDTH] >= {1'b0, b_q}) begin
                acc_d = {trial[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
            end else begin
                acc_d = sh[2*WIDTH-1:0];
            end
        end else begin
            acc_d = {upper, acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            acc_q <= {WIDTH'(0), a_i};
            b_q   <= b_i;
            div_q <= div_i;
        end else if (step_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ucsbece154a_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and mthi/mtlo writes.
module ucsbece154a_muldiv
    import ucsbece154a_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             we_hi_i,
    input  logic             we_lo_i,
    input  logic [WIDTH-1:0] wd_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CW = $clog2(MD_STEPS);

    md_state_e          state_q;
    logic [CW-1:0]      cnt_q;
    logic               div_q;
    logic               sa_q, sb_q, bz_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;

    logic               launch;
    logic               sa_d, sb_d;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   res_hi_d, res_lo_d;

    // busy_q stays high through the done cycle, so a launch needs both IDLE and !busy_q.
    assign launch = (state_q == MD_IDLE) && !busy_q && start_i;

    // Signed ops (op_i[0]==0) work on two's-complement magnitudes.
    always_comb begin
        sa_d  = ~op_i[0] & a_i[WIDTH-1];
        sb_d  = ~op_i[0] & b_i[WIDTH-1];
        a_mag = sa_d ? -a_i : a_i;
        b_mag = sb_d ? -b_i : b_i;
    end

    ucsbece154a_muldiv_dp #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst_n_i (rst_n_i),
        .load_i  (launch),
        .step_i  (state_q == MD_RUN),
        .div_i   (op_i[1]),
        .a_i     (a_mag),
        .b_i     (b_mag),
        .acc_o   (acc)
    );

    // Sign correction applied in FIX.
    always_comb begin
        prod     = (sa_q ^ sb_q) ? -acc : acc;
        quo      = (sa_q ^ sb_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = sa_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_hi_d = prod[2*WIDTH-1:WIDTH];
        res_lo_d = prod[WIDTH-1:0];
        if (div_q) begin
            if (bz_q) begin
                res_hi_d = a_raw_q;
                res_lo_d = '1;
            end else begin
                res_hi_d = rem;
                res_lo_d = quo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            a_raw_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else begin
                        if (we_hi_i) hi_q <= wd_i;
                        if (we_lo_i) lo_q <= wd_i;
                        if (start_i) begin
                            state_q <= MD_RUN;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            div_q   <= op_i[1];
                            sa_q    <= sa_d;
                            sb_q    <= sb_d;
                            bz_q    <= (b_i == '0);
                            a_raw_q <= a_i;
                        end
                    end
                end
                MD_RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(MD_STEPS - 1)) state_q <= MD_FIX;
                end
                MD_FIX: begin
                    hi_q    <= res_hi_d;
                    lo_q    <= res_lo_d;
                    done_q  <= 1'b1;
                    state_q <= MD_IDLE;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_ucsbece154a_muldiv.sv
// Self-checking bench: directed cases plus random ops against an arithmetic model.
module tb_ucsbece154a_muldiv;
    import ucsbece154a_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i, wd_i;
    logic        we_hi_i, we_lo_i;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int total = 0;
    int bad   = 0;

    ucsbece154a_muldiv #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n_i (rst_n_i),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .we_hi_i (we_hi_i),
        .we_lo_i (we_lo_i),
        .wd_i    (wd_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] p;
        x = longint'($signed(a));
        y = longint'($signed(b));
        case (op)
            MD_MULT:  begin q = x * y; p = q; return p; end
            MD_MULTU: return {32'b0, a} * {32'b0, b};
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = x / y;
                r = x % y;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Launch one op, watch 40 cycles, check timing and result; optional mid-op disturbance.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit inj);
        int nb, nd, di;
        logic [31:0] h, l, h0, l0;
        logic [63:0] exp;
        exp = model(op, a, b);
        @(negedge clk);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        h0 = hi_o; l0 = lo_o;
        nb = 0; nd = 0; di = -1; h = 'x; l = 'x;
        for (int i = 0; i < 40; i++) begin
            if (busy_o) nb++;
            if (done_o) begin nd++; di = i; h = hi_o; l = lo_o; end
            if (i == 20) chk({tag, " hold"}, {hi_o, lo_o}, {h0, l0});
            if (inj && i == 10) begin
                start_i = 1'b1; we_lo_i = 1'b1; wd_i = 32'h5555_5555;
                op_i = MD_MULTU; a_i = 32'd1; b_i = 32'd1;
            end else begin
                start_i = 1'b0; we_lo_i = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 64'(nb), 64'd34);
        chk({tag, " done_cycles"}, 64'(nd), 64'd1);
        chk({tag, " done_pos"}, 64'(di), 64'd33);
        chk({tag, " result"}, {h, l}, exp);
    endtask

    initial begin
        rst_n_i = 1'b0; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
        we_hi_i = 1'b0; we_lo_i = 1'b0; wd_i = '0;
        repeat (3) @(negedge clk);
        chk("reset", {28'(0), busy_o, done_o, 2'b00, hi_o, lo_o}, 64'd0);
        rst_n_i = 1'b1;

        run_op("mult_m3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        chk("mult_m3x7 const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("multu_ff", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_ff const", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_ff", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("mult_ff const", {hi_o, lo_o}, 64'h0000_0000_0000_0001);
        run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 1'b0);
        chk("divu_100_7 const", {hi_o, lo_o}, 64'h0000_0002_0000_000E);
        run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_m7_2 const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_by0", MD_DIV, 32'h1234_5678, 32'd0, 1'b0);
        chk("div_by0 const", {hi_o, lo_o}, 64'h1234_5678_FFFF_FFFF);
        run_op("divu_by0", MD_DIVU, 32'h1234_5678, 32'd0, 1'b0);
        chk("divu_by0 const", {hi_o, lo_o}, 64'h1234_5678_FFFF_FFFF);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf const", {hi_o, lo_o}, 64'h0000_0000_8000_0000);

        // mthi, mtlo, and both at once
        @(negedge clk); we_hi_i = 1'b1; wd_i = 32'hAAAA_0000;
        @(negedge clk); we_hi_i = 1'b0;
        chk("mthi", 64'(hi_o), 64'hAAAA_0000);
        we_lo_i = 1'b1; wd_i = 32'h0000_BBBB;
        @(negedge clk); we_lo_i = 1'b0;
        chk("mtlo", {hi_o, lo_o}, 64'hAAAA_0000_0000_BBBB);
        we_hi_i = 1'b1; we_lo_i = 1'b1; wd_i = 32'hC0DE_F00D;
        @(negedge clk); we_hi_i = 1'b0; we_lo_i = 1'b0;
        chk("mthilo", {hi_o, lo_o}, 64'hC0DE_F00D_C0DE_F00D);

        // write and start in the same cycle: write lands, result overwrites later
        op_i = MD_MULTU; a_i = 32'd3; b_i = 32'd5; start_i = 1'b1;
        we_lo_i = 1'b1; wd_i = 32'h1111_2222;
        @(negedge clk); start_i = 1'b0; we_lo_i = 1'b0;
        chk("wr_start lo", 64'(lo_o), 64'h1111_2222);
        repeat (40) @(negedge clk);
        chk("wr_start result", {hi_o, lo_o}, 64'd15);

        run_op("inject", MD_DIVU, 32'd1000, 32'd33, 1'b1);

        // asynchronous reset mid-op
        @(negedge clk); op_i = MD_DIVU; a_i = 32'd999; b_i = 32'd10; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n_i = 1'b0;
        #1 chk("async_rst", {28'(0), busy_o, done_o, 2'b00, hi_o, lo_o}, 64'd0);
        @(negedge clk); rst_n_i = 1'b1;
        run_op("multu_6x7", MD_MULTU, 32'd6, 32'd7, 1'b0);
        chk("multu_6x7 const", {hi_o, lo_o}, 64'd42);

        for (int k = 0; k < 30; k++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (k % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (k % 5 == 1) rb = ~rb + 32'd1;
            run_op($sformatf("rand%0d", k), rop, ra, rb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
